counter_snapshot_tx: RTL and testbench

- Downstream consumer of the dual 64-bit event counter (Output0 = unconditional enabled count, Output1 = prescaled count).
- On a trigger pulse, captures both counter values atomically in one cycle.
- Streams the captured values as an 18-byte frame over an 8-bit valid/ready byte interface to the debug/UART path.
- Reports overruns and counts completed frames.

---
 rtl/counter_snapshot_tx.sv | 146 ++++++++++++++
 tb/tb_counter_snapshot_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_snapshot_tx.sv
// Captures both 64-bit event counters on a trigger and streams them as an
// 18-byte frame (header, Cnt0 LSB-first, Cnt1 LSB-first, XOR checksum) over valid/ready.
module counter_snapshot_tx #(
    parameter logic [7:0] HDR = 8'hA5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Trig,
    input  logic [63:0] Cnt0,
    input  logic [63:0] Cnt1,
    output logic [7:0]  Dout,
    output logic        Dvalid,
    input  logic        Dready,
    output logic        Busy,
    output logic        Overrun,
    output logic [15:0] FrameCnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'd17;

    state_t      state_r, state_s;
    logic [4:0]  idx_r, idx_s;
    logic [7:0]  dout_r, dout_s;
    logic [63:0] snap0_r, snap1_r;
    logic        overrun_r, overrun_s;
    logic [15:0] frame_cnt_r;
    logic        capture_s;
    logic        done_s;

    function automatic logic [7:0] frame_checksum(input logic [63:0] s0, input logic [63:0] s1);
        logic [7:0] acc;
        acc = HDR;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ s0[i*8 +: 8] ^ s1[i*8 +: 8];
        end
        return acc;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [63:0] s0,
                                              input logic [63:0] s1);
        logic [127:0] payload;
        logic [4:0]   sh;
        logic [6:0]   bit_pos;
        logic [7:0]   b;
        payload = {s1, s0};
        sh      = idx - 5'd1;
        bit_pos = {sh[3:0], 3'b000};
        if (idx == 5'd0) begin
            b = HDR;
        end else if (idx <= 5'd16) begin
            b = payload[bit_pos +: 8];
        end else if (idx == LAST_IDX) begin
            b = frame_checksum(s0, s1);
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

    // Next-state, next-byte and event decode; Dout is preloaded so it never depends on Dready combinationally.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        dout_s    = dout_r;
        overrun_s = overrun_r;
        capture_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (Trig) begin
                    state_s   = SEND;
                    idx_s     = 5'd0;
                    dout_s    = HDR;
                    capture_s = 1'b1;
                end else begin
                    idx_s  = 5'd0;
                    dout_s = 8'h00;
                end
            end
            SEND: begin
                if (Trig) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                if (Dready) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = IDLE;
                        idx_s   = 5'd0;
                        dout_s  = 8'h00;
                        done_s  = 1'b1;
                    end else begin
                        idx_s  = idx_r + 5'd1;
                        dout_s = frame_byte(idx_r + 5'd1, snap0_r, snap1_r);
                    end
                end else begin
                    state_s = state_r;
                    idx_s   = idx_r;
                    dout_s  = dout_r;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 5'd0;
                dout_s  = 8'h00;
            end
        endcase
    end

    // State, snapshot and status registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= IDLE;
            idx_r       <= 5'd0;
            dout_r      <= 8'h00;
            snap0_r     <= 64'd0;
            snap1_r     <= 64'd0;
            overrun_r   <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            dout_r    <= dout_s;
            overrun_r <= overrun_s;
            if (capture_s) begin
                snap0_r <= Cnt0;
                snap1_r <= Cnt1;
            end
            if (done_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    assign Dout     = dout_r;
    assign Dvalid   = (state_r == SEND);
    assign Busy     = (state_r == SEND);
    assign Overrun  = overrun_r;
    assign FrameCnt = frame_cnt_r;

endmodule

// File: tb/tb_counter_snapshot_tx.sv
// Randomized bench for counter_snapshot_tx: a queue-based frame model checked every
// cycle, plus literal frame/counter expectations for the directed scenarios.
module tb_counter_snapshot_tx;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Trig = 1'b0;
    logic        Dready = 1'b0;
    logic [63:0] Cnt0 = 64'd0;
    logic [63:0] Cnt1 = 64'd0;
    logic [7:0]  Dout;
    logic        Dvalid;
    logic        Busy;
    logic        Overrun;
    logic [15:0] FrameCnt;

    counter_snapshot_tx #(.HDR(8'hA5)) dut (
        .Clk(Clk), .Reset(Reset), .Trig(Trig), .Cnt0(Cnt0), .Cnt1(Cnt1),
        .Dout(Dout), .Dvalid(Dvalid), .Dready(Dready), .Busy(Busy),
        .Overrun(Overrun), .FrameCnt(FrameCnt)
    );

    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;

    // Model: a frame is just a queue of bytes still to be sent
    bit          m_busy = 1'b0;
    logic [7:0]  m_q[$];
    logic [15:0] m_cnt = 16'd0;
    bit          m_ovr = 1'b0;
    logic [7:0]  rx[$];
    bit          scramble = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic build_frame(input logic [63:0] a, input logic [63:0] b);
        logic [7:0] ck;
        m_q.delete();
        m_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) m_q.push_back(a[i*8 +: 8]);
        for (int i = 0; i < 8; i++) m_q.push_back(b[i*8 +: 8]);
        ck = 8'h00;
        foreach (m_q[i]) ck = ck ^ m_q[i];
        m_q.push_back(ck);
    endtask

    task automatic cycle(input logic trig, input logic rdy, input logic rst);
        logic       xfer;
        logic [7:0] pre;
        @(negedge Clk);
        Trig = trig;
        Dready = rdy;
        Reset = rst;
        if (scramble) begin
            Cnt0 = {$urandom, $urandom};
            Cnt1 = {$urandom, $urandom};
        end
        #1;
        pre  = Dout;
        xfer = Dvalid && Dready && !Reset;
        @(posedge Clk);
        if (Reset) begin
            m_busy = 1'b0; m_q.delete(); m_cnt = 16'd0; m_ovr = 1'b0;
        end else if (m_busy) begin
            if (Trig) m_ovr = 1'b1;
            if (Dready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_cnt = m_cnt + 16'd1;
                end
            end
        end else if (Trig) begin
            build_frame(Cnt0, Cnt1);
            m_busy = 1'b1;
        end
        if (xfer) rx.push_back(pre);
        #1;
        check("Dout", Dout, m_busy ? m_q[0] : 8'h00);
        check("Dvalid", Dvalid, m_busy);
        check("Busy", Busy, m_busy);
        check("Overrun", Overrun, m_ovr);
        check("FrameCnt", FrameCnt, m_cnt);
    endtask

    // mode 0: ready high; 1: ready toggles and counters change; 2: random ready/trig and counters
    task automatic run_frame(input logic [63:0] a, input logic [63:0] b, input int mode);
        int   n;
        logic r;
        rx.delete();
        scramble = 1'b0;
        Cnt0 = a;
        Cnt1 = b;
        cycle(1'b1, 1'b1, 1'b0);
        check("first_valid_latency", Dvalid, 1'b1);
        scramble = (mode != 0);
        n = 0;
        r = 1'b1;
        while (m_busy && n < 300) begin
            if (mode == 2) cycle($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'b0);
            else cycle(1'b0, r, 1'b0);
            if (mode == 1) r = !r;
            n++;
        end
        scramble = 1'b0;
        if (m_busy) begin
            total++;
            $display("FAIL frame_timeout: frame still busy after %0d cycles, required done", n);
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[18]);
        check({name, "_len"}, rx.size(), 18);
        for (int i = 0; i < 18; i++) begin
            check(name, (i < rx.size()) ? rx[i] : 8'hxx, exp[i]);
        end
    endtask

    logic [7:0] exp1[18];
    logic [7:0] exp2[18];

    initial begin
        exp1[0] = 8'hA5; exp1[1] = 8'h01;
        for (int i = 2; i < 17; i++) exp1[i] = 8'h00;
        exp1[17] = 8'hA4;
        exp2[0] = 8'hA5;
        for (int i = 1; i <= 8; i++) exp2[i] = 8'(9 - i);
        for (int i = 9; i <= 16; i++) exp2[i] = 8'hFF;
        exp2[17] = 8'hAD;

        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("reset_Dvalid", Dvalid, 1'b0);
        check("reset_FrameCnt", FrameCnt, 16'd0);
        cycle(1'b0, 1'b1, 1'b0);

        run_frame(64'h1, 64'h0, 0);
        check_rx("frame1", exp1);
        check("frame1_cnt", FrameCnt, 16'd1);
        check("frame1_ovr", Overrun, 1'b0);

        run_frame(64'h0102030405060708, 64'hFFFFFFFFFFFFFFFF, 0);
        check_rx("frame2", exp2);

        run_frame(64'h0102030405060708, 64'hFFFFFFFFFFFFFFFF, 1);
        check_rx("frame_toggle", exp2);
        check("toggle_cnt", FrameCnt, 16'd3);

        // triggers at byte index 5 and in the byte-17 transfer cycle
        rx.delete();
        Cnt0 = 64'h0102030405060708;
        Cnt1 = 64'hFFFFFFFFFFFFFFFF;
        cycle(1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 18; j++) begin
            if (j == 6) Cnt0 = 64'hDEADBEEF00000000;
            cycle((j == 5) || (j == 17), 1'b1, 1'b0);
        end
        check_rx("frame_ovr", exp2);
        check("ovr_set", Overrun, 1'b1);
        check("ovr_cnt", FrameCnt, 16'd4);
        check("ovr_idle", Busy, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("retrig_valid", Dvalid, 1'b1);
        check("retrig_hdr", Dout, 8'hA5);
        for (int j = 0; j < 18; j++) cycle(1'b0, 1'b1, 1'b0);
        check("ovr_sticky", Overrun, 1'b1);
        check("retrig_cnt", FrameCnt, 16'd5);

        // reset mid-frame at byte index 10
        cycle(1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 10; j++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        check("rst_Dvalid", Dvalid, 1'b0);
        check("rst_Busy", Busy, 1'b0);
        check("rst_Dout", Dout, 8'h00);
        check("rst_FrameCnt", FrameCnt, 16'd0);
        check("rst_Overrun", Overrun, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 0);
        check("post_rst_hdr", rx.size() > 0 ? rx[0] : 8'hxx, 8'hA5);
        check("post_rst_len", rx.size(), 18);
        check("post_rst_cnt", FrameCnt, 16'd1);

        for (int k = 0; k < 6; k++) begin
            run_frame({$urandom, $urandom}, {$urandom, $urandom}, 2);
            check("rand_len", rx.size(), 18);
            if ($urandom_range(0, 1) == 1) cycle(1'b0, 1'b1, 1'b0);
        end

        // jump the frame counter close to wrap
        @(negedge Clk);
        force dut.frame_cnt_r = 16'hFFFE;
        #1;
        release dut.frame_cnt_r;
        m_cnt = 16'hFFFE;
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 0);
        check("wrap_ffff", FrameCnt, 16'hFFFF);
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 0);
        check("wrap_zero", FrameCnt, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
